// File: rtl/attn_pkg.sv
// Shared types and Q-format constants for the attention datapath stages.
`timescale 1ns/1ps
package attn_pkg;

    localparam int unsigned W_WIDTH    = 16;
    localparam int unsigned W_FRAC     = 15;
    localparam int unsigned V_WIDTH    = 16;
    localparam int unsigned V_FRAC     = 8;
    localparam int unsigned OUT_WIDTH  = 16;
    localparam int unsigned OUT_FRAC   = 8;

    // Right shift that maps a weight*value product back to output Q-format.
    localparam int unsigned NORM_SHIFT = W_FRAC + V_FRAC - OUT_FRAC;

    typedef logic signed [W_WIDTH-1:0]   weight_t;
    typedef logic signed [V_WIDTH-1:0]   value_t;
    typedef logic signed [OUT_WIDTH-1:0] out_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_MAC,
        ST_WRITE,
        ST_DONE
    } mac_state_t;

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational arithmetic right shift, optional round-half-up, then saturate
// from IN_WIDTH down to a signed OUT_WIDTH word.
`timescale 1ns/1ps
module fxp_round_sat #(
    parameter int unsigned IN_WIDTH  = 34,
    parameter int unsigned OUT_WIDTH = 16,
    parameter int unsigned SHIFT     = 15,
    parameter bit          ROUND     = 1'b0
) (
    input  logic signed [IN_WIDTH-1:0]  din,
    output logic signed [OUT_WIDTH-1:0] result_c
);

    // One guard bit so the rounding bias can never wrap the input.
    localparam int unsigned EXT = IN_WIDTH + 1;

    localparam logic signed [EXT-1:0] HALF = ROUND ? (EXT'(1) <<< (SHIFT - 1)) : '0;
    localparam logic signed [EXT-1:0] MAXV = EXT'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [EXT-1:0] MINV = ~MAXV;

    logic signed [EXT-1:0] biased;
    logic signed [EXT-1:0] shifted;

    always_comb begin
        biased  = EXT'(din) + HALF;
        shifted = biased >>> SHIFT;
        if (shifted > MAXV) begin
            result_c = OUT_WIDTH'(MAXV);
        end else if (shifted < MINV) begin
            result_c = OUT_WIDTH'(MINV);
        end else begin
            result_c = OUT_WIDTH'(shifted);
        end
    end

endmodule

// File: rtl/attention_value_mac.sv
// Weighted sum of value rows by softmax weights on one time-multiplexed MAC.
// Build option: ATTN_VALUE_MAC_ROUND_EN selects round-half-up instead of floor.
`timescale 1ns/1ps
module attention_value_mac
    import attn_pkg::*;
#(
    parameter int unsigned N         = 4,
    parameter int unsigned D         = 4,
    parameter int unsigned W_WIDTH   = attn_pkg::W_WIDTH,
    parameter int unsigned W_FRAC    = attn_pkg::W_FRAC,
    parameter int unsigned V_WIDTH   = attn_pkg::V_WIDTH,
    parameter int unsigned V_FRAC    = attn_pkg::V_FRAC,
    parameter int unsigned OUT_WIDTH = attn_pkg::OUT_WIDTH,
    parameter int unsigned OUT_FRAC  = attn_pkg::OUT_FRAC,
    parameter int unsigned ACC_WIDTH = W_WIDTH + V_WIDTH + $clog2(N)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        op_start,
    input  logic signed [W_WIDTH-1:0]   weight_vector [N],
    input  logic signed [V_WIDTH-1:0]   value_matrix  [N][D],
    output logic signed [OUT_WIDTH-1:0] output_vector [D],
    output logic                        op_busy,
    output logic                        op_done
);

    localparam int unsigned SHIFT  = W_FRAC + V_FRAC - OUT_FRAC;
    localparam int unsigned PROD_W = W_WIDTH + V_WIDTH;
    localparam int unsigned IW     = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned DW     = (D > 1) ? $clog2(D) : 1;

`ifdef ATTN_VALUE_MAC_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    mac_state_t                  state;
    logic                        op_start_d1;
    logic signed [ACC_WIDTH-1:0] acc;
    logic [IW-1:0]               i_cnt;
    logic [DW-1:0]               d_cnt;
    logic signed [W_WIDTH-1:0]   w_q [N];
    logic signed [V_WIDTH-1:0]   v_q [N][D];
    logic signed [PROD_W-1:0]    prod_c;
    logic signed [OUT_WIDTH-1:0] sat_c;

    assign prod_c = PROD_W'(w_q[i_cnt]) * PROD_W'(v_q[i_cnt][d_cnt]);

    fxp_round_sat #(
        .IN_WIDTH (ACC_WIDTH),
        .OUT_WIDTH(OUT_WIDTH),
        .SHIFT    (SHIFT),
        .ROUND    (ROUND_EN)
    ) u_round_sat (
        .din     (acc),
        .result_c(sat_c)
    );

    // Control FSM; op_busy/op_done are registered alongside the state they decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            op_busy     <= 1'b0;
            op_done     <= 1'b0;
            op_start_d1 <= 1'b0;
            acc         <= '0;
            i_cnt       <= '0;
            d_cnt       <= '0;
            for (int n = 0; n < int'(N); n++) begin
                w_q[n] <= '0;
                for (int k = 0; k < int'(D); k++) v_q[n][k] <= '0;
            end
            for (int k = 0; k < int'(D); k++) output_vector[k] <= '0;
        end else begin
            op_start_d1 <= op_start;
            case (state)
                ST_IDLE: begin
                    if (op_start && !op_start_d1) begin
                        state   <= ST_LATCH;
                        op_busy <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    w_q   <= weight_vector;
                    v_q   <= value_matrix;
                    acc   <= '0;
                    i_cnt <= '0;
                    d_cnt <= '0;
                    state <= ST_MAC;
                end
                ST_MAC: begin
                    acc   <= acc + ACC_WIDTH'(prod_c);
                    i_cnt <= i_cnt + IW'(1);
                    if (i_cnt == IW'(N - 1)) state <= ST_WRITE;
                end
                ST_WRITE: begin
                    output_vector[d_cnt] <= sat_c;
                    acc   <= '0;
                    i_cnt <= '0;
                    if (d_cnt == DW'(D - 1)) begin
                        state   <= ST_DONE;
                        op_busy <= 1'b0;
                        op_done <= 1'b1;
                    end else begin
                        d_cnt <= d_cnt + DW'(1);
                        state <= ST_MAC;
                    end
                end
                ST_DONE: begin
                    op_done <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    state   <= ST_IDLE;
                    op_busy <= 1'b0;
                    op_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_attention_value_mac.sv
// Directed self-checking bench for attention_value_mac (default parameters).
`timescale 1ns/1ps
module tb_attention_value_mac;

    localparam int N = 4;
    localparam int D = 4;
    localparam int LAT = 1 + D * (N + 1);

`ifdef ATTN_VALUE_MAC_ROUND_EN
    localparam logic [15:0] ONEHOT_EXP = 16'h0400;
`else
    localparam logic [15:0] ONEHOT_EXP = 16'h03FF;
`endif

    logic clk;
    logic rst_n;
    logic op_start;
    logic op_busy;
    logic op_done;
    logic signed [15:0] weight_vector [N];
    logic signed [15:0] value_matrix  [N][D];
    logic signed [15:0] output_vector [D];

    int errors = 0;
    int checks = 0;

    attention_value_mac dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op_start     (op_start),
        .weight_vector(weight_vector),
        .value_matrix (value_matrix),
        .output_vector(output_vector),
        .op_busy      (op_busy),
        .op_done      (op_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [15:0] exp);
        for (int d = 0; d < D; d++)
            check($sformatf("%s_out[%0d]", tag, d), {16'h0, output_vector[d]}, {16'h0, exp});
    endtask

    task automatic fill(input logic [15:0] w, input logic [15:0] v);
        for (int i = 0; i < N; i++) begin
            weight_vector[i] = w;
            for (int d = 0; d < D; d++) value_matrix[i][d] = v;
        end
    endtask

    // Called #1 after the start-detecting edge; returns edges until op_done.
    task automatic wait_done(input bit disturb, output int n, output bit busy_ok);
        n = 0;
        busy_ok = 1'b1;
        while (op_done !== 1'b1 && n < 100) begin
            if (op_busy !== 1'b1) busy_ok = 1'b0;
            if (disturb) begin
                if (n == 3) begin
                    op_start = 1'b0;
                    fill(16'h7FFF, 16'h7FFF);
                end
                if (n == 5) op_start = 1'b1;
                if (n == 6) op_start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_op(input string tag, input bit disturb, input logic [15:0] exp);
        int  n;
        bit  busy_ok;
        int  extra;
        @(negedge clk);
        op_start = 1'b1;
        @(posedge clk); #1;
        if (!disturb) op_start = 1'b0;
        wait_done(disturb, n, busy_ok);
        check({tag, "_latency"}, 32'(n), 32'(LAT));
        check({tag, "_busy_during"}, {31'h0, busy_ok}, 32'h1);
        check({tag, "_busy_at_done"}, {31'h0, op_busy}, 32'h0);
        extra = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (op_done) extra++;
        end
        check({tag, "_extra_done"}, 32'(extra), 32'h0);
        check_outputs(tag, exp);
    endtask

    initial begin
        int  n;
        bit  busy_ok;
        int  seen;

        rst_n    = 1'b0;
        op_start = 1'b0;
        fill(16'h0000, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'h0, op_busy}, 32'h0);
        check("reset_done", {31'h0, op_done}, 32'h0);
        check_outputs("reset", 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Uniform 0.25 weights over rows 1,2,3,4 -> 2.5
        for (int i = 0; i < N; i++) begin
            weight_vector[i] = 16'h2000;
            for (int d = 0; d < D; d++) value_matrix[i][d] = 16'(16'h0100 * (i + 1));
        end
        run_op("uniform", 1'b0, 16'h0280);

        // One-hot near-unity weight selects row 2
        fill(16'h0000, 16'h0100);
        weight_vector[2] = 16'h7FFF;
        for (int d = 0; d < D; d++) value_matrix[2][d] = 16'h0400;
        run_op("onehot", 1'b0, ONEHOT_EXP);

        fill(16'h7FFF, 16'h7FFF);
        run_op("sat_pos", 1'b0, 16'h7FFF);

        fill(16'h7FFF, 16'h8000);
        run_op("sat_neg", 1'b0, 16'h8000);

        // 0.5*2.0 - 0.5*1.0 = 0.5
        fill(16'h0000, 16'h7FFF);
        weight_vector[0] = 16'h4000;
        weight_vector[1] = 16'hC000;
        for (int d = 0; d < D; d++) begin
            value_matrix[0][d] = 16'h0200;
            value_matrix[1][d] = 16'h0100;
        end
        run_op("mixed", 1'b0, 16'h0080);

        // Operands change and op_start re-pulses mid-run; first operands must win
        for (int i = 0; i < N; i++) begin
            weight_vector[i] = 16'h2000;
            for (int d = 0; d < D; d++) value_matrix[i][d] = 16'(16'h0100 * (i + 1));
        end
        run_op("ignore_start", 1'b1, 16'h0280);

        // Reset during an operation, op_start held high through release
        fill(16'h0000, 16'h7FFF);
        weight_vector[0] = 16'h4000;
        weight_vector[1] = 16'hC000;
        for (int d = 0; d < D; d++) begin
            value_matrix[0][d] = 16'h0200;
            value_matrix[1][d] = 16'h0100;
        end
        @(negedge clk);
        op_start = 1'b1;
        @(posedge clk); #1;
        repeat (10) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("midreset_busy", {31'h0, op_busy}, 32'h0);
        check("midreset_done", {31'h0, op_done}, 32'h0);
        check_outputs("midreset", 16'h0000);
        seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (op_done) seen++;
        end
        check("midreset_no_done", 32'(seen), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("restart_busy", {31'h0, op_busy}, 32'h1);
        wait_done(1'b0, n, busy_ok);
        check("restart_latency", 32'(n), 32'(LAT));
        check("restart_busy_during", {31'h0, busy_ok}, 32'h1);
        check_outputs("restart", 16'h0080);
        op_start = 1'b0;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
